// File: rtl/rv32_mmu_pkg.sv
// Shared constants and the walker state type for the Sv32 page-table walker.
package rv32_mmu_pkg;

  localparam int unsigned PTE_V        = 0;
  localparam int unsigned PTE_R        = 1;
  localparam int unsigned PTE_W        = 2;
  localparam int unsigned PTE_X        = 3;
  localparam int unsigned PTE_PPN_LSB  = 10;
  localparam int unsigned PTE_PPN0_MSB = 19;
  localparam int unsigned PTE_PPN1_LSB = 20;
  localparam int unsigned PTE_PPN_MSB  = 29;

  localparam int unsigned PPN_W = 20;
  localparam int unsigned VPN_W = 10;

  localparam int unsigned MEM_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    L1_REQ,
    L1_WAIT,
    L0_REQ,
    L0_WAIT,
    RESP
  } ptw_state_t;

endpackage

// File: rtl/rv32_pte_check.sv
// Combinational PTE decode shared by both walk levels.
module rv32_pte_check
  import rv32_mmu_pkg::*;
(
  input  logic [31:0] pte,
  input  logic        level,
  output logic        valid,
  output logic        leaf,
  output logic        fault,
  output logic        misaligned
);

  logic reserved;
  logic unused_bits;

  // Level-1 leaf policy depends on the superpage build option and is applied by the walker.
  always_comb begin
    valid      = pte[PTE_V];
    leaf       = pte[PTE_R] | pte[PTE_X];
    reserved   = !pte[PTE_R] && pte[PTE_W];
    misaligned = level && leaf && (pte[PTE_PPN0_MSB:PTE_PPN_LSB] != '0);
    fault      = !valid || reserved || (!level && !leaf);
  end

  assign unused_bits = ^{pte[31:PTE_PPN1_LSB], pte[9:4]};

endmodule

// File: rtl/rv32_ptw.sv
// Sv32 two-level page-table walker; RV32_PTW_SUPERPAGE_EN enables level-1 superpage leaves.
module rv32_ptw
  import rv32_mmu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_vaddr,
  input  logic [PPN_W-1:0] satp_ppn,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [PPN_W-1:0] resp_ppn,
  output logic             resp_fault,
  output logic             resp_super,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [31:0]      mem_addr,
  input  logic             mem_rsp_valid,
  input  logic [31:0]      mem_rsp_data,
  output logic             busy
);

`ifdef RV32_PTW_SUPERPAGE_EN
  localparam bit SUPER_EN = 1'b1;
`else
  localparam bit SUPER_EN = 1'b0;
`endif

  localparam logic [7:0] CNT_LIMIT = 8'(MEM_TIMEOUT - 1);

  ptw_state_t       state;
  logic [VPN_W-1:0] vpn0_q;
  logic [7:0]       cnt;

  logic             chk_valid, chk_leaf, chk_fault, chk_misaligned;
  logic             l1_leaf_bad;
  logic             fin, fin_fault, fin_super, descend;
  logic [PPN_W-1:0] fin_ppn;
  logic             unused_bits;

  rv32_pte_check u_pte_check (
    .pte        (mem_rsp_data),
    .level      (state == L1_WAIT),
    .valid      (chk_valid),
    .leaf       (chk_leaf),
    .fault      (chk_fault),
    .misaligned (chk_misaligned)
  );

  assign unused_bits = ^req_vaddr[11:0];

  always_comb begin
    l1_leaf_bad = !SUPER_EN || chk_misaligned;
    fin         = 1'b0;
    fin_fault   = 1'b0;
    fin_super   = 1'b0;
    fin_ppn     = '0;
    descend     = 1'b0;
    if (state == L1_WAIT || state == L0_WAIT) begin
      if (mem_rsp_valid) begin
        if (chk_fault) begin
          fin       = 1'b1;
          fin_fault = 1'b1;
        end else if (state == L1_WAIT && chk_valid && !chk_leaf) begin
          descend = 1'b1;
        end else if (state == L0_WAIT) begin
          fin     = 1'b1;
          fin_ppn = mem_rsp_data[PTE_PPN_MSB:PTE_PPN_LSB];
        end else if (l1_leaf_bad) begin
          fin       = 1'b1;
          fin_fault = 1'b1;
        end else begin
          fin       = 1'b1;
          fin_super = 1'b1;
          fin_ppn   = {mem_rsp_data[PTE_PPN_MSB:PTE_PPN1_LSB], vpn0_q};
        end
      end else if (cnt == CNT_LIMIT) begin
        fin       = 1'b1;
        fin_fault = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_ppn      <= '0;
      resp_fault    <= 1'b0;
      resp_super    <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      busy          <= 1'b0;
      cnt           <= '0;
      vpn0_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready     <= 1'b0;
            busy          <= 1'b1;
            mem_req_valid <= 1'b1;
            mem_addr      <= {satp_ppn, req_vaddr[31:22], 2'b00};
            vpn0_q        <= req_vaddr[21:12];
            state         <= L1_REQ;
          end
        end
        L1_REQ, L0_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            cnt           <= '0;
            state         <= (state == L1_REQ) ? L1_WAIT : L0_WAIT;
          end
        end
        L1_WAIT, L0_WAIT: begin
          if (fin) begin
            resp_valid <= 1'b1;
            resp_fault <= fin_fault;
            resp_super <= SUPER_EN && fin_super;
            resp_ppn   <= fin_ppn;
            state      <= RESP;
          end else if (descend) begin
            mem_addr      <= {mem_rsp_data[PTE_PPN_MSB:PTE_PPN_LSB], vpn0_q, 2'b00};
            mem_req_valid <= 1'b1;
            state         <= L0_REQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rv32_ptw.md
# rv32_ptw

Sv32-style two-level hardware page-table walker that services TLB-miss requests issued by the translation unit and returns a 20-bit physical page number or a fault. It is the responder on the MMU miss interface and the initiator on a single-outstanding, in-order memory read port. One walk is in flight at a time.

## Interface
- MEM_TIMEOUT, 64: cycles waited for `mem_rsp_valid` in a WAIT state before the walk faults; range 2..255.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: miss request valid.
- `req_ready` out 1: walker idle and able to accept a request.
- `req_vaddr` in 32: faulting virtual address; VPN1=[31:22], VPN0=[21:12].
- `satp_ppn` in 20: root page-table PPN, sampled on accept.
- `resp_valid` out 1: walk result valid.
- `resp_ready` in 1: consumer accepts result.
- `resp_ppn` out 20: translated PPN; 0 on fault.
- `resp_fault` out 1: page fault or timeout.
- `resp_super` out 1: result came from a level-1 leaf.
- `mem_req_valid` out 1: PTE read request.
- `mem_req_ready` in 1: memory accepts request.
- `mem_addr` out 32: PTE byte address, word aligned.
- `mem_rsp_valid` in 1: PTE read data valid.
- `mem_rsp_data` in 32: PTE.
- `busy` out 1: high in every state except IDLE.

## Operation
- PTE fields: V=0, R=1, W=2, X=3, PPN=[29:10] (bits [31:30] ignored).
- States: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch `req_vaddr` and `satp_ppn`; go to L1_REQ.
- L1_REQ: `mem_req_valid`=1, `mem_addr`={root_ppn, VPN1, 2'b00}; stay until `mem_req_ready`; go to L1_WAIT.
- L1_WAIT: on `mem_rsp_valid`, decode PTE:
  - V=0, or R=0 with W=1: fault, go to RESP.
  - R|X set (leaf): superpage handling per Configuration; go to RESP.
  - otherwise (pointer): next address {PTE.PPN, VPN0, 2'b00}; go to L0_REQ.
- L0_REQ: as L1_REQ with the level-0 address; go to L0_WAIT.
- L0_WAIT: on `mem_rsp_valid`: V=0, R=0 with W=1, or non-leaf -> fault; else `resp_ppn`=PTE.PPN. Go to RESP.
- RESP: `resp_valid`=1 with stable `resp_ppn`/`resp_fault`/`resp_super`; on `resp_ready`, go to IDLE.
- Timeout: in a WAIT state the counter increments each cycle without `mem_rsp_valid`; when it reaches MEM_TIMEOUT, fault and go to RESP. The counter clears on entry to each WAIT state.
- `mem_rsp_valid` outside L1_WAIT/L0_WAIT, including a stale response after a timeout, is ignored.
- A fault forces `resp_ppn`=0 and `resp_super`=0.

## Timing
- Reset values: `req_ready`=0 during reset and 1 in the cycle after; `resp_valid`, `resp_fault`, `resp_super`, `mem_req_valid`, `busy`=0; `resp_ppn`, `mem_addr`=0; state=IDLE.
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.
- With `mem_req_ready`=1 and the response one cycle after the request, accept occurs at cycle 0:
  - level-0 walk: `resp_valid` at cycle 5.
  - superpage or level-1 fault: `resp_valid` at cycle 3.
- `resp_valid` holds until `resp_ready`. A new request is accepted no earlier than the cycle after the RESP handshake.
- `rst` asserted in any state abandons the walk immediately. No response is produced and later memory responses are ignored.

## Configuration
- `RV32_PTW_SUPERPAGE_EN` defined:
  - level-1 leaf with PTE[19:10]==0 -> `resp_ppn`={PTE[29:20], VPN0}, `resp_super`=1.
  - level-1 leaf with PTE[19:10]!=0 (misaligned) -> fault.
- Not defined: every level-1 leaf faults and `resp_super` is tied to 0.

## Structure
- Package `rv32_mmu_pkg` holds:
  - PTE bit-index constants and PPN/VPN width constants (20/10/10).
  - the walker state enum.
  - the default timeout constant.
- One combinational sub-module, `rv32_pte_check`, takes a PTE and a level and returns valid, leaf, fault and misaligned; it is instantiated once and shared by both levels.

## Test plan
- Two-level hit: satp_ppn=0x00010, vaddr=0x00403ABC; L1 read @0x00010004 returns 0x00008001 (pointer, PPN=0x00020); L0 read @0x0002000C returns 0x0ABCD00F -> `resp_ppn`=0x2AF34, fault=0, super=0, `resp_valid` at cycle 5.
- Invalid L1: L1 returns 0x00000000 -> `resp_fault`=1, `resp_ppn`=0, `resp_valid` at cycle 3, no L0 request issued.
- Superpage (macro on): vaddr=0x00C05000, L1 returns 0x1230000F -> `resp_ppn`=0x48C05, super=1. Same with L1=0x1230040F -> fault. With the macro off, both cases fault.
- Timeout: never assert `mem_rsp_valid` -> fault exactly MEM_TIMEOUT cycles after entering L1_WAIT. A stale response injected in IDLE does not change state.
- Backpressure: `mem_req_ready` low for 4 cycles -> `mem_addr` stable throughout; `resp_ready` low for 3 cycles -> `resp_valid` and data held, `req_ready`=0.
- Reset mid-walk in L0_WAIT -> all outputs return to reset values next cycle; a following walk completes correctly.
